instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 112 +++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle encoder with 2-entry output FIFO and issue counter
//
// Packs an RV32I instruction word from the fields on the input bundle,
// combinationally. The word and its illegal flag are buffered in a two-entry
// FIFO. A saturating counter tracks completed output handshakes.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input bundle handshake
//   fmt                  0=R 1=I 2=S 3=B 4=U 5=J, 6..7 reserved (illegal)
//   opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   out_valid / out_ready  output word handshake
//   out_instr, out_illegal head-of-FIFO word and its illegal flag
//   clr_cnt              synchronous clear of issued_cnt
//   issued_cnt, cnt_sat  output-transfer count, high when at MAX_CNT
module instr_encoder #(
  parameter int CNT_W   = 8,
  parameter int MAX_CNT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);

  logic [31:0] enc_word;
  logic        enc_illegal;

  // Immediate bits outside a format's field are simply dropped.
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_illegal = 1'b1;
    endcase
    if (opcode[1:0] != 2'b11) enc_illegal = 1'b1;
    // Branch/jump offsets are in halfwords; an odd byte offset cannot be encoded.
    if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) enc_illegal = 1'b1;
    if (enc_illegal) enc_word = '0;
  end

  logic [32:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign in_ready    = (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_instr   = mem[rd_ptr][31:0];
  assign out_illegal = mem[rd_ptr][32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_illegal, enc_word};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
    end else if (clr_cnt) begin
      issued_cnt <= '0;
    end else if (pop && issued_cnt != CNT_MAX) begin
      issued_cnt <= issued_cnt + 1'b1;
    end
  end

  assign cnt_sat = (issued_cnt == CNT_MAX);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

  localparam int CNT_W = 8;
  localparam int MAXC  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd, rs1, rs2;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_illegal;
  logic             clr_cnt;
  logic [CNT_W-1:0] issued_cnt;
  logic             cnt_sat;

  instr_encoder #(.CNT_W(CNT_W), .MAX_CNT(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_illegal(out_illegal), .clr_cnt(clr_cnt),
    .issued_cnt(issued_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: places each field at its bit offset arithmetically.
  function automatic logic [32:0] ref_encode(input int f, input int op, input int f3,
      input int f7, input int d, input int s1, input int s2, input logic [31:0] im);
    longint w;
    bit bad;
    bad = (f > 5) || ((op % 4) != 3) || ((f == 3 || f == 5) && im[0]);
    w = op;
    case (f)
      0: w += (d << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (f7 << 25);
      1: w += (d << 7) + (f3 << 12) + (s1 << 15) + ((im & 32'hFFF) << 20);
      2: w += ((im & 32'h1F) << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (((im >> 5) & 32'h7F) << 25);
      3: w += (((im >> 11) & 1) << 7) + (((im >> 1) & 32'hF) << 8) + (f3 << 12) + (s1 << 15)
            + (s2 << 20) + (((im >> 5) & 32'h3F) << 25) + (((im >> 12) & 1) << 31);
      4: w += (d << 7) + (im & 32'hFFFFF000);
      5: w += (d << 7) + (im & 32'h000FF000) + (((im >> 11) & 1) << 20)
            + (((im >> 1) & 32'h3FF) << 21) + (((im >> 20) & 1) << 31);
      default: w = 0;
    endcase
    if (bad) w = 0;
    return {bad, w[31:0]};
  endfunction

  // Behavioural model: a queue of expected words plus a saturating count.
  logic [32:0] mq[$];
  int          m_issued;
  int          m_size;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_size   <= 0;
      m_issued <= 0;
    end else begin
      if (out_ready && m_size > 0) void'(mq.pop_front());
      if (in_valid && m_size < 2)
        mq.push_back(ref_encode(int'(fmt), int'(opcode), int'(funct3), int'(funct7),
                                int'(rd), int'(rs1), int'(rs2), imm));
      m_size <= m_size + ((in_valid && m_size < 2) ? 1 : 0) - ((out_ready && m_size > 0) ? 1 : 0);
      if (clr_cnt) m_issued <= 0;
      else if (out_ready && m_size > 0 && m_issued < MAXC) m_issued <= m_issued + 1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model out_valid", 32'(out_valid), 32'(m_size > 0));
      check("model in_ready", 32'(in_ready), 32'(m_size < 2));
      check("model issued_cnt", 32'(issued_cnt), 32'(m_issued));
      check("model cnt_sat", 32'(cnt_sat), 32'(m_issued == MAXC));
      if (m_size > 0) begin
        check("model out_instr", out_instr, mq[0][31:0]);
        check("model out_illegal", 32'(out_illegal), 32'(mq[0][32]));
      end
    end
  end

  task automatic set_b(input int f, input int op, input int f3, input int f7,
                       input int d, input int s1, input int s2, input logic [31:0] im);
    fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
    rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im; in_valid = 1'b1;
  endtask

  task automatic set_idx(input int i);
    case (i)
      0: set_b(0, 7'h33, 0, 0, 3, 1, 2, 32'd0);        // ADD x3,x1,x2
      1: set_b(2, 7'h23, 2, 0, 0, 1, 2, 32'd8);        // SW x2,8(x1)
      2: set_b(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC); // BEQ x0,x0,-4
      default: set_b(5, 7'h6F, 0, 0, 1, 0, 0, 32'd8);  // JAL x1,8
    endcase
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
  endtask

  logic [31:0] lit [4] = '{32'h002081B3, 32'h0020A423, 32'hFE000EE3, 32'h008000EF};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    set_b(0, 0, 0, 0, 0, 0, 0, 32'd0); in_valid = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_instr", out_instr, 32'd0);
    check("reset out_illegal", 32'(out_illegal), 32'd0);
    check("reset issued_cnt", 32'(issued_cnt), 32'd0);
    check("reset cnt_sat", 32'(cnt_sat), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cmp_en = 1'b1;

    // I-type ADDI x1,x0,5 with one-cycle latency
    @(negedge clk); set_b(1, 7'h13, 0, 0, 1, 0, 0, 32'd5);
    @(posedge clk); #1;
    check("addi out_valid", 32'(out_valid), 32'd1);
    check("addi out_instr", out_instr, 32'h00500093);
    check("addi out_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("addi issued_cnt", 32'(issued_cnt), 32'd1);

    // R/S/B/J streamed back-to-back
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_idx(i);
      @(posedge clk); #1;
      check("stream out_instr", out_instr, lit[i]);
      check("stream in_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clk); in_valid = 1'b0;
    pulse_clr();

    // Backpressure: third bundle must wait while two are held
    @(negedge clk); out_ready = 1'b0; set_idx(0);
    @(negedge clk); set_idx(1);
    @(negedge clk); set_idx(2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp head stable", out_instr, lit[0]);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp second word", out_instr, lit[1]);
    @(posedge clk); #1;
    check("bp third word", out_instr, lit[2]);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp drained", 32'(out_valid), 32'd0);
    pulse_clr();

    // Illegal bundles: reserved fmt, bad opcode LSBs, odd branch offset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) set_b(7, 7'h33, 0, 0, 3, 1, 2, 32'd0);
      else if (i == 1) set_b(1, 7'h10, 0, 0, 1, 0, 0, 32'd5);
      else set_b(3, 7'h63, 0, 0, 0, 0, 0, 32'd3);
      @(posedge clk); #1;
      check("illegal out_instr", out_instr, 32'd0);
      check("illegal flag", 32'(out_illegal), 32'd1);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("illegal issued_cnt", 32'(issued_cnt), 32'd3);
    pulse_clr();

    // Saturation at MAX_CNT=4 after six transfers
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); set_idx(i % 4);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("sat issued_cnt", 32'(issued_cnt), 32'd4);
    check("sat cnt_sat", 32'(cnt_sat), 32'd1);
    @(negedge clk); set_idx(3);
    @(negedge clk); in_valid = 1'b0; clr_cnt = 1'b1;
    @(posedge clk); #1;
    check("clr beats incr", 32'(issued_cnt), 32'd0);
    check("clr cnt_sat", 32'(cnt_sat), 32'd0);
    @(negedge clk); clr_cnt = 1'b0;

    // Asynchronous reset with two entries held
    @(negedge clk); out_ready = 1'b0; set_idx(0);
    @(negedge clk); set_idx(1);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #3; rst_n = 1'b0; #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst issued_cnt", 32'(issued_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post rst empty", 32'(out_valid), 32'd0);
    @(negedge clk); set_b(1, 7'h13, 0, 0, 1, 0, 0, 32'd5);
    @(posedge clk); #1;
    check("post rst latency", out_instr, 32'h00500093);
    check("post rst valid", 32'(out_valid), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
